fp_minmax_stream: RTL and testbench
===================================

Name: fp_minmax_stream

Overview:
- Sequential, parametrised successor to the single-pair FP min/max unit.
- Reduces a stream of IEEE-754 operands, one per cycle over a valid/ready input, to a single running minimum or maximum using RISC-V fmin/fmax semantics.
- Returns the winning value, the index of its first occurrence, the element count and the NV flag.
- Sits beside the FPU execute stage and serves vector-style reductions without per-pair issue.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored mantissa width. W = 1+EXP_W+MAN_W.
- CNT_W, 8, index width. Maximum stream length is 2^CNT_W elements.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  block accepts operand
- in_data  in  W  operand bits
- in_last  in  1  final operand of stream
- in_mode  in  1  0=min, 1=max; sampled only on first operand of a stream
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  W  min/max result
- out_flags  out  5  {NV,DZ,OF,UF,NX}; only bit 4 ever set
- out_index  out  CNT_W  index of winning operand
- out_count  out  CNT_W+1  number of operands consumed

Behaviour:
- Reset (reset==0, async): state=IDLE; in_ready=0 during reset, then 1; out_valid=0; out_data, out_flags, out_index, out_count all 0; accumulator, mode and counters cleared. A stream in progress is discarded.
- Handshake: a transfer occurs when valid&ready is high on a clock edge. in_ready is 1 in IDLE and ACC, 0 in DONE. Outputs are registered and stable while out_valid=1 and out_ready=0.
- FSM:
  - IDLE: on input transfer, latch mode, load the accumulator with the operand and its index 0, set count=1. Go to DONE if in_last, else ACC.
  - ACC: on each transfer, compare and update, increment count. Go to DONE on in_last, or when count reaches 2^CNT_W (forced last, irrespective of in_last).
  - DONE: out_valid=1. On out_ready go to IDLE; out_valid falls the next cycle. No input is accepted in the DONE cycle.
- Latency: out_valid rises exactly one cycle after the last operand's transfer. Throughput is 1 operand/cycle.
- Classification (internal, per operand):
  - NaN: exp all ones and mant!=0.
  - sNaN: NaN with mant MSB=0.
  - qNaN: NaN with mant MSB=1.
- Update rule, for accumulator A and new operand B:
  - Any sNaN: NV set sticky for the rest of the stream.
  - A and B both NaN: A becomes canonical NaN (0, exp all ones, mant MSB only: 0x7FC00000 at defaults). Index is unchanged.
  - Only A is NaN: take B and its index.
  - Only B is NaN: keep A.
  - Otherwise: compare numerically, treating -0 < +0. Take B only if strictly better: smaller for min, larger for max. Ties keep A, i.e. the earliest index.
  - The first operand is loaded as-is, except an sNaN/qNaN first operand is stored as canonical NaN and NV is set if it is an sNaN.
  - A single-element stream returns the operand itself, or canonical NaN if it is a NaN.
- Comparison: sign-magnitude. Opposite signs: the negative operand is smaller. Same sign: compare {exp,mant} unsigned, inverting the sense when negative. The comparison is combinational within the ACC cycle.
- All-NaN stream: out_data=canonical NaN, out_index=0, NV=1 if any sNaN was seen.
- Non-NaN results are returned bit-exact; no canonicalisation. Infinities compare normally.
- in_mode is ignored after the first operand.

Test Plan:
- Max stream {0x3F800000, 0xC0000000, 0x40600000 last} -> out_valid one cycle after 3rd transfer, out_data=0x40600000, out_index=2, out_count=3, out_flags=0.
- Min {0x00000000, 0x80000000 last} -> 0x80000000, idx 1. Max of the same stream -> 0x00000000, idx 0. Equal operands {0x40000000, 0x40000000} -> idx 0.
- Min {0x7FC00001, 0x40000000 last} -> 0x40000000, idx 1, flags=0. Replacing the first operand with 0x7F800001 -> same data, flags=0x10. {0x7FC00000, 0xFFC00005} -> 0x7FC00000, idx 0, flags=0.
- Backpressure: hold out_ready=0 for 3 cycles after result -> outputs stable, in_ready=0. Raise out_ready -> IDLE next cycle, in_ready=1, and the next stream starts with fresh flags.
- Pull reset low after 2 operands of a stream -> all outputs 0 immediately. After release, a new 1-element stream 0xBF800000 returns 0xBF800000, idx 0, count 1.
- CNT_W=2: max of 4 operands with in_last=0 throughout -> result forced after the 4th, out_count=4. A 5th operand presented is not accepted until after out_ready.

Source files
------------

// File: rtl/fp_minmax_stream.sv
// fp_minmax_stream
//   Reduces a stream of IEEE-754 operands, one per cycle, to a running
//   minimum or maximum using RISC-V fmin/fmax semantics. Returns the
//   winning value, the index of its first occurrence, the number of
//   operands consumed and the NV flag.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   operand valid
//   in_ready   block accepts an operand (low while a result is pending)
//   in_data    operand bits, W = 1+EXP_W+MAN_W
//   in_last    final operand of the stream
//   in_mode    0 = min, 1 = max; only sampled on the first operand
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   out_data   min/max result
//   out_flags  {NV,DZ,OF,UF,NX}; only NV is ever set
//   out_index  index of the winning operand
//   out_count  number of operands consumed
module fp_minmax_stream #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int CNT_W = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_data,
    input  logic                   in_last,
    input  logic                   in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data,
    output logic [4:0]             out_flags,
    output logic [CNT_W-1:0]       out_index,
    output logic [CNT_W:0]         out_count
);

    localparam int W = 1 + EXP_W + MAN_W;

    // Canonical quiet NaN: positive, exponent all ones, only mantissa MSB set.
    localparam logic [W-1:0] CNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Count value that forces the stream to close regardless of in_last.
    localparam logic [CNT_W:0] CNT_FULL = {1'b1, {CNT_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Operand classification and ordering
    // ------------------------------------------------------------------
    function automatic logic is_nan(input logic [W-1:0] x);
        return (&x[W-2:MAN_W]) && (|x[MAN_W-1:0]);
    endfunction

    function automatic logic is_snan(input logic [W-1:0] x);
        return is_nan(x) && !x[MAN_W-1];
    endfunction

    // Strict sign-magnitude less-than on non-NaN values; -0 < +0 falls out
    // of the opposite-sign rule.
    function automatic logic fp_lt(input logic [W-1:0] x, input logic [W-1:0] y);
        logic r;
        if (x[W-1] != y[W-1])
            r = x[W-1];
        else if (x[W-1])
            r = x[W-2:0] > y[W-2:0];
        else
            r = x[W-2:0] < y[W-2:0];
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state, state_nx;
    logic [W-1:0]     acc, acc_nx;
    logic [CNT_W-1:0] idx, idx_nx;
    logic [CNT_W:0]   cnt, cnt_nx;
    logic             mode, mode_nx;
    logic             nv, nv_nx;
    logic             load_out;
    logic             rdy_q;

    logic             xfer;
    logic             a_nan, b_nan, b_snan;
    logic             b_better;
    logic [CNT_W-1:0] cur_idx;

    // rdy_q keeps in_ready low while reset is asserted and for the edge
    // that releases it.
    assign in_ready  = rdy_q && (state != DONE);
    assign out_valid = (state == DONE);
    assign xfer      = in_valid && in_ready;

    assign a_nan   = is_nan(acc);
    assign b_nan   = is_nan(in_data);
    assign b_snan  = is_snan(in_data);
    // Index of the operand being accepted equals the count so far.
    assign cur_idx = cnt[CNT_W-1:0];

    // Strictly better only; ties keep the accumulator (earliest index).
    assign b_better = mode ? fp_lt(acc, in_data) : fp_lt(in_data, acc);

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        idx_nx   = idx;
        cnt_nx   = cnt;
        mode_nx  = mode;
        nv_nx    = nv;
        load_out = 1'b0;

        case (state)
            IDLE: begin
                if (xfer) begin
                    mode_nx = in_mode;
                    acc_nx  = b_nan ? CNAN : in_data;
                    idx_nx  = '0;
                    cnt_nx  = {{CNT_W{1'b0}}, 1'b1};
                    nv_nx   = b_snan;
                    if (in_last) begin
                        state_nx = DONE;
                        load_out = 1'b1;
                    end else begin
                        state_nx = ACC;
                    end
                end
            end

            ACC: begin
                if (xfer) begin
                    cnt_nx = cnt + 1'b1;
                    nv_nx  = nv | b_snan;
                    if (a_nan && b_nan) begin
                        acc_nx = CNAN;
                    end else if (a_nan) begin
                        acc_nx = in_data;
                        idx_nx = cur_idx;
                    end else if (!b_nan && b_better) begin
                        acc_nx = in_data;
                        idx_nx = cur_idx;
                    end
                    if (in_last || (cnt_nx == CNT_FULL)) begin
                        state_nx = DONE;
                        load_out = 1'b1;
                    end
                end
            end

            DONE: begin
                if (out_ready)
                    state_nx = IDLE;
            end

            default: state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nx;
            rdy_q <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            idx  <= '0;
            cnt  <= '0;
            mode <= 1'b0;
            nv   <= 1'b0;
        end else begin
            acc  <= acc_nx;
            idx  <= idx_nx;
            cnt  <= cnt_nx;
            mode <= mode_nx;
            nv   <= nv_nx;
        end
    end

    // Result registers are captured from the final update so they are
    // valid the cycle after the last transfer and hold through DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_flags <= '0;
            out_index <= '0;
            out_count <= '0;
        end else if (load_out) begin
            out_data  <= acc_nx;
            out_flags <= {nv_nx, 4'b0000};
            out_index <= idx_nx;
            out_count <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_fp_minmax_stream.sv
module tb_fp_minmax_stream;

    logic        clock;
    logic        reset;
    logic        in_valid, in_ready, in_last, in_mode;
    logic [31:0] in_data;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_flags;
    logic [7:0]  out_index;
    logic [8:0]  out_count;

    // Second instance with a 4-element maximum stream length.
    logic        c2_in_valid, c2_in_ready, c2_in_last, c2_in_mode;
    logic [31:0] c2_in_data;
    logic        c2_out_valid, c2_out_ready;
    logic [31:0] c2_out_data;
    logic [4:0]  c2_out_flags;
    logic [1:0]  c2_out_index;
    logic [2:0]  c2_out_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  idx;
        logic [8:0]  cnt;
        logic [4:0]  flags;
    } exp_t;

    exp_t sb[$];

    fp_minmax_stream dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .out_index(out_index), .out_count(out_count)
    );

    fp_minmax_stream #(.EXP_W(8), .MAN_W(23), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset),
        .in_valid(c2_in_valid), .in_ready(c2_in_ready), .in_data(c2_in_data),
        .in_last(c2_in_last), .in_mode(c2_in_mode),
        .out_valid(c2_out_valid), .out_ready(c2_out_ready), .out_data(c2_out_data),
        .out_flags(c2_out_flags), .out_index(c2_out_index), .out_count(c2_out_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present one operand and hold it until it transfers; returns #1 after
    // the transfer edge.
    task automatic send(input logic [31:0] d, input bit last, input bit mode);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = last; in_mode = mode;
        while (!in_ready && n < 20) begin
            @(posedge clock); #1; n++;
        end
        if (n >= 20) chk("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send2(input logic [31:0] d, input bit last, input bit mode);
        int n = 0;
        c2_in_valid = 1'b1; c2_in_data = d; c2_in_last = last; c2_in_mode = mode;
        while (!c2_in_ready && n < 20) begin
            @(posedge clock); #1; n++;
        end
        if (n >= 20) chk("send2_timeout", 64'(c2_in_ready), 64'd1);
        @(posedge clock); #1;
        c2_in_valid = 1'b0; c2_in_last = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input int i, input int c, input logic [4:0] f);
        exp_t e;
        e.data = d; e.idx = 8'(i); e.cnt = 9'(c); e.flags = f;
        sb.push_back(e);
    endtask

    // Called #1 after the last transfer edge: the result must already be up.
    task automatic get_result(input string tag, input int hold);
        exp_t e;
        chk({tag, "_latency"}, 64'(out_valid), 64'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_data"},  64'(out_data),  64'(e.data));
        chk({tag, "_index"}, 64'(out_index), 64'(e.idx));
        chk({tag, "_count"}, 64'(out_count), 64'(e.cnt));
        chk({tag, "_flags"}, 64'(out_flags), 64'(e.flags));
        chk({tag, "_inrdy"}, 64'(in_ready),  64'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clock); #1;
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_data"},  64'(out_data),  64'(e.data));
            chk({tag, "_hold_index"}, 64'(out_index), 64'(e.idx));
            chk({tag, "_hold_flags"}, 64'(out_flags), 64'(e.flags));
            chk({tag, "_hold_inrdy"}, 64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk({tag, "_drop_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_idle_inrdy"}, 64'(in_ready),  64'd1);
    endtask

    task automatic stream(input string tag, input bit mode, input int n,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic [31:0] ed, input int ei, input logic [4:0] ef,
                          input int hold);
        logic [31:0] ops [3];
        ops[0] = a; ops[1] = b; ops[2] = c;
        push(ed, ei, n, ef);
        for (int i = 0; i < n; i++) send(ops[i], (i == n - 1), mode);
        get_result(tag, hold);
    endtask

    initial begin
        exp_t e2;
        reset = 1'b0;
        in_valid = 0; in_data = 0; in_last = 0; in_mode = 0; out_ready = 0;
        c2_in_valid = 0; c2_in_data = 0; c2_in_last = 0; c2_in_mode = 0; c2_out_ready = 0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_inrdy",  64'(in_ready),  64'd0);
        chk("rst_valid",  64'(out_valid), 64'd0);
        chk("rst_data",   64'(out_data),  64'd0);
        chk("rst_flags",  64'(out_flags), 64'd0);
        chk("rst_index",  64'(out_index), 64'd0);
        chk("rst_count",  64'(out_count), 64'd0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("post_rst_inrdy", 64'(in_ready), 64'd1);

        // Directed streams (mode 1 = max)
        stream("max3",   1, 3, 32'h3F800000, 32'hC0000000, 32'h40600000, 32'h40600000, 2, 5'h00, 0);
        stream("min_z",  0, 2, 32'h00000000, 32'h80000000, 32'h0,        32'h80000000, 1, 5'h00, 0);
        stream("max_z",  1, 2, 32'h00000000, 32'h80000000, 32'h0,        32'h00000000, 0, 5'h00, 0);
        stream("tie",    0, 2, 32'h40000000, 32'h40000000, 32'h0,        32'h40000000, 0, 5'h00, 0);
        stream("qnan_a", 0, 2, 32'h7FC00001, 32'h40000000, 32'h0,        32'h40000000, 1, 5'h00, 0);
        // sNaN first with backpressure; the following stream must have clean flags
        stream("snan_a", 0, 2, 32'h7F800001, 32'h40000000, 32'h0,        32'h40000000, 1, 5'h10, 3);
        stream("nan2",   0, 2, 32'h7FC00000, 32'hFFC00005, 32'h0,        32'h7FC00000, 0, 5'h00, 0);
        stream("neg",    0, 3, 32'hC0000000, 32'hC0400000, 32'hBF800000, 32'hC0400000, 1, 5'h00, 0);
        stream("inf",    1, 3, 32'hFF800000, 32'h7F800000, 32'h7F800000, 32'h7F800000, 1, 5'h00, 0);
        stream("single", 1, 1, 32'h7F800001, 32'h0,        32'h0,        32'h7FC00000, 0, 5'h10, 0);
        stream("snan_b", 0, 3, 32'h40000000, 32'h7F800001, 32'h3F800000, 32'h3F800000, 2, 5'h10, 0);

        // Mode changes after the first operand are ignored (stays min)
        push(32'h3F800000, 0, 2, 5'h00);
        send(32'h3F800000, 0, 0);
        send(32'h40000000, 1, 1);
        get_result("mode_ign", 0);

        // Reset mid-stream discards the partial stream
        send(32'h40000000, 0, 1);
        send(32'h3F800000, 0, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_inrdy", 64'(in_ready),  64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data",  64'(out_data),  64'd0);
        chk("mid_rst_count", 64'(out_count), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        stream("after_rst", 0, 1, 32'hBF800000, 32'h0, 32'h0, 32'hBF800000, 0, 5'h00, 0);

        // CNT_W=2 instance: stream closes by itself after 4 operands
        e2.data = 32'h40800000; e2.idx = 8'd1; e2.cnt = 9'd4; e2.flags = 5'h00;
        sb.push_back(e2);
        send2(32'h3F800000, 0, 1);
        send2(32'h40800000, 0, 1);
        send2(32'h40000000, 0, 0);
        send2(32'h40400000, 0, 0);
        e2 = sb.pop_front();
        chk("c2_forced_valid", 64'(c2_out_valid), 64'd1);
        chk("c2_forced_data",  64'(c2_out_data),  64'(e2.data));
        chk("c2_forced_index", 64'(c2_out_index), 64'(e2.idx));
        chk("c2_forced_count", 64'(c2_out_count), 64'(e2.cnt));
        chk("c2_forced_flags", 64'(c2_out_flags), 64'(e2.flags));
        // A 5th operand waits while the result is pending
        c2_in_valid = 1'b1; c2_in_data = 32'h41000000; c2_in_last = 1'b1; c2_in_mode = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("c2_blocked_inrdy", 64'(c2_in_ready),  64'd0);
            chk("c2_blocked_valid", 64'(c2_out_valid), 64'd1);
            @(posedge clock); #1;
        end
        c2_out_ready = 1'b1;
        @(posedge clock); #1;
        c2_out_ready = 1'b0;
        chk("c2_idle_valid", 64'(c2_out_valid), 64'd0);
        chk("c2_idle_inrdy", 64'(c2_in_ready),  64'd1);
        @(posedge clock); #1;
        c2_in_valid = 1'b0; c2_in_last = 1'b0;
        chk("c2_fifth_valid", 64'(c2_out_valid), 64'd1);
        chk("c2_fifth_data",  64'(c2_out_data),  64'h41000000);
        chk("c2_fifth_index", 64'(c2_out_index), 64'd0);
        chk("c2_fifth_count", 64'(c2_out_count), 64'd1);
        c2_out_ready = 1'b1;
        @(posedge clock); #1;
        c2_out_ready = 1'b0;
        chk("c2_final_valid", 64'(c2_out_valid), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
